// File: rtl/axi_master_burst_engine_if.sv
// AXI4 bus bundle between the burst engine (master) and a memory/NoC slave.
// User widths are carried for completeness; the engine drives every user output to zero.
interface axi_master_burst_engine_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_lock;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_qos;
  logic [3:0]          aw_region;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_lock;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_qos;
  logic [3:0]          ar_region;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_master_burst_engine.sv
// AXI4 burst master: registered AR/AW slots, pass-through R/W/B streams,
// outstanding-burst limits and a burst-length queue that decouples W from AW.
module axi_master_burst_engine #(
  parameter int unsigned AXI_DATA_WIDTH     = 64,
  parameter int unsigned AXI_ADDR_WIDTH     = 64,
  parameter int unsigned AXI_ID_WIDTH       = 4,
  parameter int unsigned AXI_USER_WIDTH     = 1,
  parameter int unsigned MAX_OUTSTANDING_RD = 4,
  parameter int unsigned MAX_OUTSTANDING_WR = 4,
  parameter logic [1:0]  BURST_TYPE         = 2'b01
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req_valid_i,
  output logic                        rd_req_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_req_addr_i,
  input  logic [7:0]                  rd_req_len_i,
  input  logic [2:0]                  rd_req_size_i,
  input  logic [AXI_ID_WIDTH-1:0]     rd_req_id_i,
  output logic                        rd_data_valid_o,
  input  logic                        rd_data_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
  output logic                        rd_last_o,
  output logic [1:0]                  rd_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     rd_id_o,
  input  logic                        wr_req_valid_i,
  output logic                        wr_req_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_req_addr_i,
  input  logic [7:0]                  wr_req_len_i,
  input  logic [2:0]                  wr_req_size_i,
  input  logic [AXI_ID_WIDTH-1:0]     wr_req_id_i,
  input  logic                        wr_data_valid_i,
  output logic                        wr_data_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb_i,
  output logic                        wr_rsp_valid_o,
  input  logic                        wr_rsp_ready_i,
  output logic [1:0]                  wr_rsp_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     wr_rsp_id_o,
  output logic                        err_o,
  input  logic                        err_clr_i,
  output logic                        rd_busy_o,
  output logic                        wr_busy_o,
  axi_master_burst_engine_if.master   axi
);
  localparam int unsigned RD_CW = $clog2(MAX_OUTSTANDING_RD + 1);
  localparam int unsigned WR_CW = $clog2(MAX_OUTSTANDING_WR + 1);
  localparam int unsigned QD    = MAX_OUTSTANDING_WR;
  localparam int unsigned QPW   = (QD > 1) ? $clog2(QD) : 1;
  localparam int unsigned QCW   = $clog2(QD + 1);

  logic                      init_q;
  logic                      ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
  logic [7:0]                ar_len_q, aw_len_q;
  logic [2:0]                ar_size_q, aw_size_q;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q, aw_id_q;
  logic [RD_CW-1:0]          rd_outst_q, rd_outst_d;
  logic [WR_CW-1:0]          wr_outst_q, wr_outst_d;
  logic [7:0]                len_mem_q [QD];
  logic [QPW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [QCW-1:0]            qcnt_q, qcnt_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      err_q, err_d;
  logic rd_accept, wr_accept, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic rd_dec, wr_dec, q_empty, q_full, q_push, q_pop, w_last, err_set;
  logic unused_user;

  function automatic logic [QPW-1:0] ptr_inc(input logic [QPW-1:0] p);
    return (p == QPW'(QD - 1)) ? '0 : p + QPW'(1);
  endfunction

  assign q_empty = (qcnt_q == '0);
  assign q_full  = (qcnt_q == QCW'(QD));

  // init_q keeps the request readies low until the first edge after reset release
  assign rd_req_ready_o = init_q && !ar_valid_q && (rd_outst_q < RD_CW'(MAX_OUTSTANDING_RD));
  assign wr_req_ready_o = init_q && !aw_valid_q && (wr_outst_q < WR_CW'(MAX_OUTSTANDING_WR)) && !q_full;

  assign rd_accept = rd_req_valid_i && rd_req_ready_o;
  assign wr_accept = wr_req_valid_i && wr_req_ready_o;
  assign ar_hs     = ar_valid_q && axi.ar_ready;
  assign aw_hs     = aw_valid_q && axi.aw_ready;
  assign r_hs      = axi.r_valid && rd_data_ready_i;
  assign w_hs      = wr_data_valid_i && axi.w_ready && !q_empty;
  assign b_hs      = axi.b_valid && wr_rsp_ready_i;
  assign w_last    = (beat_cnt_q == len_mem_q[rptr_q]);
  assign rd_dec    = r_hs && axi.r_last && (rd_outst_q != '0);
  assign wr_dec    = b_hs && (wr_outst_q != '0);
  assign q_push    = wr_accept;
  assign q_pop     = w_hs && w_last;
  assign err_set   = (r_hs && (axi.r_resp != 2'b00)) ||
                     (b_hs && ((axi.b_resp != 2'b00) || (wr_outst_q == '0)));

  assign axi.ar_valid  = ar_valid_q;
  assign axi.ar_addr   = ar_addr_q;
  assign axi.ar_len    = ar_len_q;
  assign axi.ar_size   = ar_size_q;
  assign axi.ar_id     = ar_id_q;
  assign axi.ar_burst  = BURST_TYPE;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = '0;
  assign axi.ar_prot   = '0;
  assign axi.ar_qos    = '0;
  assign axi.ar_region = '0;
  assign axi.ar_user   = '0;
  assign axi.aw_valid  = aw_valid_q;
  assign axi.aw_addr   = aw_addr_q;
  assign axi.aw_len    = aw_len_q;
  assign axi.aw_size   = aw_size_q;
  assign axi.aw_id     = aw_id_q;
  assign axi.aw_burst  = BURST_TYPE;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = '0;
  assign axi.aw_prot   = '0;
  assign axi.aw_qos    = '0;
  assign axi.aw_region = '0;
  assign axi.aw_user   = '0;

  assign rd_data_valid_o = axi.r_valid;
  assign axi.r_ready     = rd_data_ready_i;
  assign rd_data_o       = axi.r_data;
  assign rd_last_o       = axi.r_last;
  assign rd_resp_o       = axi.r_resp;
  assign rd_id_o         = axi.r_id;

  // W beats only flow while a burst length is queued; they may run ahead of AW
  assign axi.w_valid     = wr_data_valid_i && !q_empty;
  assign wr_data_ready_o = axi.w_ready && !q_empty;
  assign axi.w_data      = wr_data_i;
  assign axi.w_strb      = wr_strb_i;
  assign axi.w_last      = w_last;
  assign axi.w_user      = '0;

  assign wr_rsp_valid_o = axi.b_valid;
  assign axi.b_ready    = wr_rsp_ready_i;
  assign wr_rsp_resp_o  = axi.b_resp;
  assign wr_rsp_id_o    = axi.b_id;

  assign err_o       = err_q;
  assign rd_busy_o   = (rd_outst_q != '0);
  assign wr_busy_o   = (wr_outst_q != '0);
  assign unused_user = ^{axi.b_user, axi.r_user};

  always_comb begin
    ar_valid_d = ar_valid_q;
    aw_valid_d = aw_valid_q;
    rd_outst_d = rd_outst_q;
    wr_outst_d = wr_outst_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    qcnt_d     = qcnt_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    if (rd_accept)   ar_valid_d = 1'b1;
    else if (ar_hs)  ar_valid_d = 1'b0;
    if (wr_accept)   aw_valid_d = 1'b1;
    else if (aw_hs)  aw_valid_d = 1'b0;

    if (rd_accept && !rd_dec)      rd_outst_d = rd_outst_q + RD_CW'(1);
    else if (!rd_accept && rd_dec) rd_outst_d = rd_outst_q - RD_CW'(1);
    if (wr_accept && !wr_dec)      wr_outst_d = wr_outst_q + WR_CW'(1);
    else if (!wr_accept && wr_dec) wr_outst_d = wr_outst_q - WR_CW'(1);

    if (q_push) wptr_d = ptr_inc(wptr_q);
    if (q_pop)  rptr_d = ptr_inc(rptr_q);
    if (q_push && !q_pop)      qcnt_d = qcnt_q + QCW'(1);
    else if (!q_push && q_pop) qcnt_d = qcnt_q - QCW'(1);

    if (w_hs) beat_cnt_d = w_last ? 8'd0 : beat_cnt_q + 8'd1;

    if (err_clr_i)    err_d = 1'b0;
    else if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      rd_outst_q <= '0;
      wr_outst_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      qcnt_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      ar_valid_q <= ar_valid_d;
      aw_valid_q <= aw_valid_d;
      rd_outst_q <= rd_outst_d;
      wr_outst_q <= wr_outst_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      qcnt_q     <= qcnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      aw_id_q   <= '0;
    end else begin
      if (rd_accept) begin
        ar_addr_q <= rd_req_addr_i;
        ar_len_q  <= rd_req_len_i;
        ar_size_q <= rd_req_size_i;
        ar_id_q   <= rd_req_id_i;
      end
      if (wr_accept) begin
        aw_addr_q <= wr_req_addr_i;
        aw_len_q  <= wr_req_len_i;
        aw_size_q <= wr_req_size_i;
        aw_id_q   <= wr_req_id_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) len_mem_q[wptr_q] <= wr_req_len_i;
  end
endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Directed bench for the AXI burst engine; the bench itself plays the AXI slave.
module tb_axi_master_burst_engine;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int UW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req_valid_i, rd_req_ready_o;
  logic [AW-1:0] rd_req_addr_i;
  logic [7:0]    rd_req_len_i;
  logic [2:0]    rd_req_size_i;
  logic [IW-1:0] rd_req_id_i;
  logic          rd_data_valid_o, rd_data_ready_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;
  logic [1:0]    rd_resp_o;
  logic [IW-1:0] rd_id_o;
  logic          wr_req_valid_i, wr_req_ready_o;
  logic [AW-1:0] wr_req_addr_i;
  logic [7:0]    wr_req_len_i;
  logic [2:0]    wr_req_size_i;
  logic [IW-1:0] wr_req_id_i;
  logic          wr_data_valid_i, wr_data_ready_o;
  logic [DW-1:0] wr_data_i;
  logic [DW/8-1:0] wr_strb_i;
  logic          wr_rsp_valid_o, wr_rsp_ready_i;
  logic [1:0]    wr_rsp_resp_o;
  logic [IW-1:0] wr_rsp_id_o;
  logic          err_o, err_clr_i, rd_busy_o, wr_busy_o;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  axi_master_burst_engine_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .USER_W(UW)) axi ();

  axi_master_burst_engine #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
    .MAX_OUTSTANDING_RD(4), .MAX_OUTSTANDING_WR(4), .BURST_TYPE(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_req_addr_i(rd_req_addr_i), .rd_req_len_i(rd_req_len_i),
    .rd_req_size_i(rd_req_size_i), .rd_req_id_i(rd_req_id_i),
    .rd_data_valid_o(rd_data_valid_o), .rd_data_ready_i(rd_data_ready_i),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_resp_o(rd_resp_o), .rd_id_o(rd_id_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_req_addr_i(wr_req_addr_i), .wr_req_len_i(wr_req_len_i),
    .wr_req_size_i(wr_req_size_i), .wr_req_id_i(wr_req_id_i),
    .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
    .wr_rsp_valid_o(wr_rsp_valid_o), .wr_rsp_ready_i(wr_rsp_ready_i),
    .wr_rsp_resp_o(wr_rsp_resp_o), .wr_rsp_id_o(wr_rsp_id_o),
    .err_o(err_o), .err_clr_i(err_clr_i), .rd_busy_o(rd_busy_o), .wr_busy_o(wr_busy_o),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    rd_req_valid_i = 0; rd_req_addr_i = '0; rd_req_len_i = '0; rd_req_size_i = 3'd3; rd_req_id_i = '0;
    rd_data_ready_i = 0;
    wr_req_valid_i = 0; wr_req_addr_i = '0; wr_req_len_i = '0; wr_req_size_i = 3'd3; wr_req_id_i = '0;
    wr_data_valid_i = 0; wr_data_i = '0; wr_strb_i = '0; wr_rsp_ready_i = 0; err_clr_i = 0;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_id = '0; axi.b_resp = '0; axi.b_user = '0;
    axi.r_valid = 0; axi.r_id = '0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 0; axi.r_user = '0;
  endtask

  task automatic rd_issue(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    logic ok;
    ok = 0;
    rd_req_addr_i = addr; rd_req_len_i = len; rd_req_id_i = id; rd_req_valid_i = 1;
    for (int i = 0; i < 20; i++) begin
      #1 ok = rd_req_ready_o;
      tick();
      if (ok) break;
    end
    rd_req_valid_i = 0;
    check_vec("rd_accept", ok, 1);
  endtask

  task automatic wr_issue(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    logic ok;
    ok = 0;
    wr_req_addr_i = addr; wr_req_len_i = len; wr_req_id_i = id; wr_req_valid_i = 1;
    for (int i = 0; i < 20; i++) begin
      #1 ok = wr_req_ready_o;
      tick();
      if (ok) break;
    end
    wr_req_valid_i = 0;
    check_vec("wr_accept", ok, 1);
  endtask

  task automatic r_beat(input logic [63:0] data, input logic last, input logic [1:0] resp, input logic [3:0] id);
    axi.r_valid = 1; axi.r_data = data; axi.r_last = last; axi.r_resp = resp; axi.r_id = id;
    rd_data_ready_i = 1;
    tick();
    axi.r_valid = 0; axi.r_last = 0; axi.r_resp = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] lastv;
    drive_idle();
    wr_data_valid_i = 1;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_ar_valid", axi.ar_valid, 0);
    check_vec("rst_aw_valid", axi.aw_valid, 0);
    check_vec("rst_w_valid", axi.w_valid, 0);
    check_vec("rst_rd_rdy", rd_req_ready_o, 0);
    check_vec("rst_wr_rdy", wr_req_ready_o, 0);
    check_vec("rst_err", err_o, 0);
    check_vec("rst_busy", {rd_busy_o, wr_busy_o}, 0);
    wr_data_valid_i = 0;
    rst_n = 1;
    tick();
    check_vec("rdy_after_rst", {rd_req_ready_o, wr_req_ready_o}, 2'b11);

    // single read, slave holds AR one cycle
    rd_issue(64'h1000, 8'd3, 4'd2);
    check_vec("ar_valid", axi.ar_valid, 1);
    check_vec("ar_addr", axi.ar_addr, 64'h1000);
    check_vec("ar_len", axi.ar_len, 3);
    check_vec("ar_size", axi.ar_size, 3);
    check_vec("ar_id", axi.ar_id, 2);
    check_vec("ar_burst", axi.ar_burst, 2'b01);
    check_vec("rd_rdy_slot", rd_req_ready_o, 0);
    check_vec("rd_busy_1", rd_busy_o, 1);
    tick();
    check_vec("ar_hold", {axi.ar_valid, axi.ar_addr}, {1'b1, 64'h1000});
    axi.ar_ready = 1;
    tick();
    axi.ar_ready = 0;
    check_vec("ar_drop", axi.ar_valid, 0);
    check_vec("rd_rdy_free", rd_req_ready_o, 1);
    for (int b = 0; b < 4; b++) begin
      axi.r_valid = 1; axi.r_data = 64'hA0 + 64'(b); axi.r_last = (b == 3); axi.r_id = 4'd2;
      rd_data_ready_i = 1;
      #1;
      check_vec("r_pass", {rd_data_valid_o, rd_data_o, rd_last_o, rd_id_o, axi.r_ready},
                {1'b1, 64'hA0 + 64'(b), (b == 3), 4'd2, 1'b1});
      check_vec("rd_busy_beat", rd_busy_o, 1);
      tick();
    end
    axi.r_valid = 0; axi.r_last = 0;
    check_vec("rd_busy_done", rd_busy_o, 0);

    // outstanding read limit
    axi.ar_ready = 1;
    for (int i = 0; i < 4; i++) rd_issue(64'h2000 + 64'(i * 256), 8'd0, 4'(i));
    tick();
    check_vec("rd_rdy_full", rd_req_ready_o, 0);
    tick();
    check_vec("rd_rdy_full2", rd_req_ready_o, 0);
    rd_req_addr_i = 64'h3000; rd_req_len_i = 0; rd_req_id_i = 4'd4; rd_req_valid_i = 1;
    axi.r_valid = 1; axi.r_last = 1; axi.r_id = 0; rd_data_ready_i = 1;
    #1 check_vec("rd_rdy_pre_last", rd_req_ready_o, 0);
    tick();
    axi.r_valid = 0; axi.r_last = 0;
    check_vec("rd_rdy_back", rd_req_ready_o, 1);
    tick();
    rd_req_valid_i = 0;
    check_vec("rd5_ar_valid", axi.ar_valid, 1);
    tick();
    check_vec("rd_rdy_full3", rd_req_ready_o, 0);
    r_beat(64'h0, 1, 2'b00, 4'd1);
    check_vec("rd_rdy_at3", rd_req_ready_o, 1);
    // accept and final last beat in the same cycle: count must stay at 3
    rd_req_addr_i = 64'h3100; rd_req_id_i = 4'd5; rd_req_valid_i = 1;
    axi.r_valid = 1; axi.r_last = 1;
    #1 check_vec("rd_rdy_simul", rd_req_ready_o, 1);
    tick();
    rd_req_valid_i = 0; axi.r_valid = 0; axi.r_last = 0;
    check_vec("simul_ar_valid", axi.ar_valid, 1);
    tick();
    check_vec("simul_cnt_rdy", rd_req_ready_o, 1);
    r_beat(64'h0, 1, 2'b00, 4'd3);
    r_beat(64'h0, 1, 2'b00, 4'd4);
    check_vec("drain_busy", rd_busy_o, 1);
    r_beat(64'h0, 1, 2'b00, 4'd5);
    check_vec("drain_idle", rd_busy_o, 0);

    // read error response and clear
    rd_issue(64'h4000, 8'd1, 4'd3);
    tick();
    axi.ar_ready = 0;
    r_beat(64'h11, 0, 2'b00, 4'd3);
    check_vec("err_ok_beat", err_o, 0);
    r_beat(64'h22, 1, 2'b10, 4'd3);
    check_vec("err_set", err_o, 1);
    tick();
    check_vec("err_sticky", err_o, 1);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    check_vec("err_clr", err_o, 0);
    axi.r_valid = 1; axi.r_resp = 2'b10; axi.r_last = 0; err_clr_i = 1;
    tick();
    axi.r_valid = 0; axi.r_resp = 2'b00; err_clr_i = 0;
    check_vec("err_clr_prio", err_o, 0);

    // W ahead of AW, AW held off for 10 cycles
    axi.w_ready = 1;
    wr_issue(64'h5000, 8'd7, 4'd5);
    check_vec("aw_payload", {axi.aw_valid, axi.aw_addr, axi.aw_len, axi.aw_id, axi.aw_burst},
              {1'b1, 64'h5000, 8'd7, 4'd5, 2'b01});
    check_vec("wr_busy", wr_busy_o, 1);
    for (int k = 0; k < 8; k++) begin
      wr_data_valid_i = 1; wr_data_i = 64'(k) + 64'h50; wr_strb_i = 8'hFF;
      #1;
      check_vec("w_beat", {axi.w_valid, wr_data_ready_o, axi.w_last, axi.w_data},
                {1'b1, 1'b1, (k == 7), 64'(k) + 64'h50});
      tick();
    end
    #1;
    check_vec("w_empty", {axi.w_valid, wr_data_ready_o}, 2'b00);
    check_vec("aw_pending", axi.aw_valid, 1);
    wr_data_valid_i = 0;
    tick();
    axi.aw_ready = 1;
    tick();
    axi.aw_ready = 0;
    check_vec("aw_drop", axi.aw_valid, 0);
    axi.b_valid = 1; axi.b_id = 4'd5; axi.b_resp = 2'b00; wr_rsp_ready_i = 1;
    #1 check_vec("b_pass", {wr_rsp_valid_o, wr_rsp_id_o, wr_rsp_resp_o, axi.b_ready},
                 {1'b1, 4'd5, 2'b00, 1'b1});
    tick();
    axi.b_valid = 0;
    check_vec("wr_idle", {wr_busy_o, err_o}, 2'b00);

    // back-to-back writes of len 0, 2, 0
    axi.aw_ready = 1;
    wr_issue(64'h6000, 8'd0, 4'd1);
    wr_issue(64'h6100, 8'd2, 4'd2);
    wr_issue(64'h6200, 8'd0, 4'd3);
    tick();
    check_vec("wr_rdy_q3", wr_req_ready_o, 1);
    lastv = 5'b11001;
    for (int k = 0; k < 5; k++) begin
      wr_data_valid_i = 1; wr_data_i = 64'(k);
      #1 check_vec("b2b_last", {axi.w_valid, axi.w_last}, {1'b1, lastv[k]});
      tick();
    end
    #1 check_vec("b2b_empty", axi.w_valid, 0);
    wr_data_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      axi.b_valid = 1; axi.b_id = 4'(k + 1);
      tick();
      axi.b_valid = 0;
      if (k == 1) check_vec("b2b_busy", wr_busy_o, 1);
    end
    check_vec("b2b_idle", wr_busy_o, 0);
    axi.b_valid = 1;
    tick();
    axi.b_valid = 0;
    check_vec("b_stray", {wr_busy_o, err_o}, 2'b01);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;

    // async reset in the middle of a W burst
    rd_issue(64'h7000, 8'd0, 4'd1);
    wr_issue(64'h8000, 8'd3, 4'd6);
    tick();
    wr_data_valid_i = 1;
    #1 check_vec("pre_rst_w", axi.w_valid, 1);
    tick();
    #2 rst_n = 0;
    #1;
    check_vec("arst_valids", {axi.ar_valid, axi.aw_valid, axi.w_valid, wr_data_ready_o}, 0);
    check_vec("arst_busy", {rd_busy_o, wr_busy_o, err_o}, 0);
    check_vec("arst_rdy", {rd_req_ready_o, wr_req_ready_o}, 0);
    drive_idle();
    tick();
    rst_n = 1;
    tick();
    wr_data_valid_i = 1; axi.w_ready = 1;
    #1 check_vec("post_rst", {axi.w_valid, wr_req_ready_o, rd_req_ready_o}, 3'b011);
    wr_data_valid_i = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule
